noc_output_port: RTL and testbench
==================================

Name: noc_output_port

Overview:
- Downstream consumer of the 5-input matrix arbiter in one router output direction.
- Builds the arbiter's request vector from the heads of five input buffers and takes the one-hot grant.
- Holds a wormhole lock on the granted input until that packet's tail flit is sent.
- Muxes flits onto a registered output link and tracks credit-based flow control toward the downstream router.

Parameters:
- FLIT_W, 32, flit payload width in bits.
- CREDITS, 4, downstream buffer depth; this is the credit count after reset.
- N_IN, 5, number of inputs; fixed at 5 to match the arbiter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  5  a flit is present at the head of input i.
- in_head  in  5  the head flit of input i is a packet head.
- in_tail  in  5  the head flit of input i is a packet tail (head and tail both set = single-flit packet).
- in_flit  in  5*FLIT_W  head flit of each input; input i occupies bits [i*FLIT_W +: FLIT_W].
- in_pop  out  5  one-hot; input i's flit is consumed this cycle.
- arb_req  out  5  request vector to the arbiter.
- arb_grant  in  5  grant from the arbiter; combinational, same cycle as arb_req.
- out_valid  out  1  a flit is on the output link.
- out_flit  out  FLIT_W  output flit data.
- out_tail  out  1  the output flit is a tail.
- credit_in  in  1  the downstream router freed one buffer slot.
- err  out  1  sticky error: non-one-hot grant, or credit overflow.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, owner=0, credits=CREDITS.
  - out_valid=0, out_flit=0, out_tail=0, err=0.
  - Combinational outputs during reset: arb_req=0, in_pop=0.
- A reset in mid-packet drops the lock with no tail emitted; upstream flushes separately.
- State machine has two states, IDLE and LOCKED.
- IDLE:
  - arb_req = in_valid & in_head when credits>0, else 0.
  - arb_req is zero whenever a send is impossible, so the arbiter's priority only updates on a real transfer.
  - If arb_grant is one-hot and it is a subset of arb_req, with winning input g: in_pop[g]=1 and the head flit is sent; owner<=g.
  - If in_tail[g]=1 (single-flit packet), stay in IDLE; otherwise go to LOCKED.
  - If arb_grant is non-zero and either not one-hot or not a subset of arb_req: no transfer, err<=1.
- LOCKED:
  - arb_req=0.
  - Send when in_valid[owner] and credits>0: in_pop[owner]=1.
  - A send with in_tail[owner]=1 returns the block to IDLE on the next cycle.
  - A new head never preempts the lock. If in_head[owner] arrives before a tail, it is forwarded as body data; upstream is responsible for well-formed packets.
- Send (registered output):
  - On the next clk edge: out_valid<=1, out_flit<=in_flit[sel], out_tail<=in_tail[sel].
  - Cycles with no send: out_valid<=0; out_flit and out_tail hold their previous values.
  - Latency from grant or pop to out_valid is exactly 1 cycle.
  - Throughput is 1 flit/cycle, given credits.
- Credits (counter width $clog2(CREDITS+1)):
  - Send alone: decrement.
  - credit_in alone: increment.
  - Send and credit_in in the same cycle: unchanged.
  - Sends are gated at credits=0, so the counter never underflows.
  - credit_in at credits=CREDITS (with no send): counter saturates and err<=1.
- No combinational path from credit_in to any output.
- The arb_grant → in_pop path is combinational; this is required by the arbiter's same-cycle grant.

Decomposition:
- Shared package noc_pkg:
  - N_PORTS=5 and FLIT_W.
  - Port index type (3 bits).
  - state enum {IDLE, LOCKED}.
  - One-hot→index function.
  - onehot check function.
- One sub-module, noc_credit_counter: parameter CREDITS; ports clk, rst, dec, inc, credits, avail, overflow.
- The FSM and the data mux stay in noc_output_port.

Test Plan:
- After reset: out_valid=0, credits=4, arb_req=0.
  - Then in_valid=5'b00100, in_head=5'b00100, tb grant=5'b00100 → in_pop=5'b00100, owner=2, and out_valid=1 with out_flit=in_flit[2] the next cycle.
- 3-flit packet on input 1 while input 3 keeps requesting a head:
  - arb_req=0 during flits 2–3; input 3 is not popped until the cycle after input 1's tail.
  - Then arb_req=5'b01000.
- CREDITS=4, no credit_in, 6 single-flit packets offered back-to-back → exactly 4 sent, then arb_req=0.
  - One credit_in pulse → 1 more flit sent 1 cycle later.
- Send and credit_in in the same cycle at credits=2 → credits stays 2; a credit_in pulse at credits=4 → err=1 and credits stays 4.
- grant=5'b00110, or a grant on a non-requesting input → no in_pop, out_valid=0 the next cycle, err=1.
- rst asserted while LOCKED after 1 of 3 flits → state=IDLE, credits=4, out_valid=0 the next cycle; a fresh head from any input is then granted normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and helpers for the router output-port slice.
package noc_pkg;

    localparam int unsigned N_PORTS = 5;
    localparam int unsigned FLIT_W  = 32;
    localparam int unsigned IDX_W   = 3;

    typedef logic [IDX_W-1:0]   port_idx_t;
    typedef logic [N_PORTS-1:0] port_vec_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Exactly one bit set.
    function automatic logic is_onehot(input port_vec_t v);
        return (v != '0) && ((v & (v - port_vec_t'(1))) == '0);
    endfunction

    // Index of the set bit; only meaningful for a one-hot input.
    function automatic port_idx_t onehot_to_idx(input port_vec_t v);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (v[i]) idx = port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit tracker: one credit per free slot in the next router's buffer.
module noc_credit_counter #(
    parameter  int unsigned CREDITS = 4,
    localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_dec,
    input  logic          i_inc,
    output logic [CW-1:0] o_credits,
    output logic          o_avail,
    output logic          o_overflow
);

    logic [CW-1:0] r_credits;
    logic          w_full;

    assign w_full     = (r_credits == CW'(CREDITS));
    assign o_credits  = r_credits;
    assign o_avail    = (r_credits != '0);
    assign o_overflow = i_inc && !i_dec && w_full;

    // A simultaneous send and return cancel; an extra return saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_credits <= CW'(CREDITS);
        end else if (i_dec && !i_inc) begin
            r_credits <= r_credits - CW'(1);
        end else if (i_inc && !i_dec && !w_full) begin
            r_credits <= r_credits + CW'(1);
        end
    end

endmodule

// File: rtl/noc_output_port.sv
// Router output port: feeds the 5-input arbiter, holds a wormhole lock per packet,
// and drives a registered link gated by downstream credits.
module noc_output_port
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W  = noc_pkg::FLIT_W,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned N_IN    = noc_pkg::N_PORTS
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_IN-1:0]        i_in_valid,
    input  logic [N_IN-1:0]        i_in_head,
    input  logic [N_IN-1:0]        i_in_tail,
    input  logic [N_IN*FLIT_W-1:0] i_in_flit,
    output logic [N_IN-1:0]        o_in_pop,
    output logic [N_IN-1:0]        o_arb_req,
    input  logic [N_IN-1:0]        i_arb_grant,
    output logic                   o_out_valid,
    output logic [FLIT_W-1:0]      o_out_flit,
    output logic                   o_out_tail,
    input  logic                   i_credit_in,
    output logic                   o_err
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    state_e        r_state;
    state_e        w_state_next;
    port_idx_t     r_owner;
    port_idx_t     w_sel;
    logic          w_send;
    logic          w_grant_bad;
    logic          w_avail;
    logic          w_overflow;
    logic [CW-1:0] w_credits;
    logic          w_unused;

    noc_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_dec      (w_send),
        .i_inc      (i_credit_in),
        .o_credits  (w_credits),
        .o_avail    (w_avail),
        .o_overflow (w_overflow)
    );

    // The count itself is only observed through o_avail here.
    assign w_unused = ^w_credits;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Single-flit packets never take the lock; the tail flit releases it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_send && !i_in_tail[w_sel])  w_state_next = LOCKED;
            LOCKED:  if (w_send && i_in_tail[r_owner]) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request only when a transfer could complete, so arbiter priority moves on real sends.
    always_comb begin
        o_arb_req   = '0;
        o_in_pop    = '0;
        w_send      = 1'b0;
        w_sel       = r_owner;
        w_grant_bad = 1'b0;
        if (!i_rst) begin
            case (r_state)
                IDLE: begin
                    if (w_avail) o_arb_req = i_in_valid & i_in_head;
                    w_sel = onehot_to_idx(i_arb_grant);
                    if (is_onehot(i_arb_grant) && ((i_arb_grant & ~o_arb_req) == '0)) begin
                        w_send = 1'b1;
                    end else if (i_arb_grant != '0) begin
                        w_grant_bad = 1'b1;
                    end
                end
                LOCKED:  w_send = i_in_valid[r_owner] && w_avail;
                default: w_send = 1'b0;
            endcase
            if (w_send) o_in_pop = port_vec_t'(1) << w_sel;
        end
    end

    // Link register: data and tail hold across idle cycles, errors are sticky.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner     <= '0;
            o_out_valid <= 1'b0;
            o_out_flit  <= '0;
            o_out_tail  <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_out_valid <= w_send;
            if (w_send) begin
                o_out_flit <= i_in_flit[w_sel*FLIT_W +: FLIT_W];
                o_out_tail <= i_in_tail[w_sel];
            end
            if (w_send && (r_state == IDLE)) r_owner <= w_sel;
            o_err <= o_err | w_grant_bad | w_overflow;
        end
    end

endmodule

// File: tb/tb_noc_output_port.sv
// Directed vector bench for noc_output_port with an arbiter stand-in for the credit run.
module tb_noc_output_port;

    logic         clk;
    logic         rst;
    logic [4:0]   in_valid;
    logic [4:0]   in_head;
    logic [4:0]   in_tail;
    logic [159:0] in_flit;
    logic [4:0]   in_pop;
    logic [4:0]   arb_req;
    logic [4:0]   arb_grant;
    logic         out_valid;
    logic [31:0]  out_flit;
    logic         out_tail;
    logic         credit_in;
    logic         err;

    int total;
    int bad;

    noc_output_port #(
        .FLIT_W  (32),
        .CREDITS (4),
        .N_IN    (5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .i_in_head   (in_head),
        .i_in_tail   (in_tail),
        .i_in_flit   (in_flit),
        .o_in_pop    (in_pop),
        .o_arb_req   (arb_req),
        .i_arb_grant (arb_grant),
        .o_out_valid (out_valid),
        .o_out_flit  (out_flit),
        .o_out_tail  (out_tail),
        .i_credit_in (credit_in),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] valid;
        logic [4:0] head;
        logic [4:0] tail;
        logic [4:0] grant;
        logic       cin;
        logic [4:0] pop;
        logic [4:0] req;
        logic       ov;
        logic [2:0] src;
        logic       otail;
        logic       err;
        logic [2:0] cred;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    function automatic logic [31:0] flit_of(input int i, input int tag);
        return {8'hA5, 8'(tag), 8'(i), 8'h3C};
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                         input logic [4:0] g, input logic c, input int tag);
        rst       = r;
        in_valid  = v;
        in_head   = h;
        in_tail   = t;
        arb_grant = g;
        credit_in = c;
        for (int i = 0; i < 5; i++) in_flit[i*32 +: 32] = flit_of(i, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_flit;
        int pops;
        int sends;

        total = 0;
        bad   = 0;
        exp_flit = '0;

        //                rst   valid     head      tail      grant     cin   pop       req       ov    src   otl   err   cred
        tbl[0]  = '{1'b1, 5'b11111, 5'b11111, 5'b11111, 5'b00001, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4};
        tbl[1]  = '{1'b0, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b0, 3'd3};
        tbl[2]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3};
        tbl[3]  = '{1'b0, 5'b01010, 5'b01010, 5'b00000, 5'b00010, 1'b0, 5'b00010, 5'b01010, 1'b1, 3'd1, 1'b0, 1'b0, 3'd2};
        tbl[4]  = '{1'b0, 5'b01010, 5'b01000, 5'b00000, 5'b00000, 1'b1, 5'b00010, 5'b00000, 1'b1, 3'd1, 1'b0, 1'b0, 3'd2};
        tbl[5]  = '{1'b0, 5'b01010, 5'b01000, 5'b00010, 5'b00000, 1'b0, 5'b00010, 5'b00000, 1'b1, 3'd1, 1'b1, 1'b0, 3'd1};
        tbl[6]  = '{1'b0, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 1'b0, 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 5'b01000, 5'b01000, 5'b01000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 5'b01000, 5'b01000, 5'b01000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1};
        tbl[9]  = '{1'b0, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 1'b0, 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1};
        tbl[11] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2};
        tbl[12] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3};
        tbl[13] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4};
        tbl[14] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1, 1'b1, 3'd4};
        tbl[15] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4};
        tbl[16] = '{1'b0, 5'b00110, 5'b00110, 5'b00110, 5'b00110, 1'b0, 5'b00000, 5'b00110, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4};
        tbl[17] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4};
        tbl[18] = '{1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00100, 1'b0, 5'b00000, 5'b00001, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4};
        tbl[19] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4};
        tbl[20] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4};
        tbl[21] = '{1'b0, 5'b10000, 5'b10000, 5'b00000, 5'b10000, 1'b0, 5'b10000, 5'b10000, 1'b1, 3'd4, 1'b0, 1'b0, 3'd3};
        tbl[22] = '{1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3};
        tbl[23] = '{1'b0, 5'b10001, 5'b10001, 5'b00000, 5'b00000, 1'b0, 5'b10000, 5'b00000, 1'b1, 3'd4, 1'b0, 1'b0, 3'd2};
        tbl[24] = '{1'b0, 5'b10000, 5'b00000, 5'b10000, 5'b00000, 1'b0, 5'b10000, 5'b00000, 1'b1, 3'd4, 1'b1, 1'b0, 3'd1};
        tbl[25] = '{1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00001, 5'b00001, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0};
        tbl[26] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4};
        tbl[27] = '{1'b0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, 1'b0, 5'b00010, 5'b00010, 1'b1, 3'd1, 1'b0, 1'b0, 3'd3};
        tbl[28] = '{1'b1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4};
        tbl[29] = '{1'b0, 5'b00110, 5'b00100, 5'b00100, 5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b0, 3'd3};

        drive(1'b1, '0, '0, '0, '0, 1'b0, 0);
        @(posedge clk);
        #1;

        for (int r = 0; r < NV; r++) begin
            drive(tbl[r].rst, tbl[r].valid, tbl[r].head, tbl[r].tail, tbl[r].grant, tbl[r].cin, r);
            #2;
            chk("in_pop",  r, 32'(in_pop),  32'(tbl[r].pop));
            chk("arb_req", r, 32'(arb_req), 32'(tbl[r].req));
            if (tbl[r].rst)     exp_flit = '0;
            else if (tbl[r].ov) exp_flit = flit_of(int'(tbl[r].src), r);
            @(posedge clk);
            #1;
            chk("out_valid", r, 32'(out_valid),     32'(tbl[r].ov));
            chk("out_flit",  r, out_flit,            exp_flit);
            chk("out_tail",  r, 32'(out_tail),      32'(tbl[r].otail));
            chk("err",       r, 32'(err),           32'(tbl[r].err));
            chk("credits",   r, 32'(dut.w_credits), 32'(tbl[r].cred));
        end

        // Credit exhaustion: six back-to-back single-flit packets, arbiter grants what is requested.
        drive(1'b1, '0, '0, '0, '0, 1'b0, 0);
        @(posedge clk);
        #1;
        pops  = 0;
        sends = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 1'b0, 100 + k);
            #1;
            arb_grant = arb_req;
            #1;
            if (in_pop != '0) pops++;
            @(posedge clk);
            #1;
            if (out_valid) sends++;
        end
        chk("exhaust_pops",  100, 32'(pops),  32'd4);
        chk("exhaust_sends", 100, 32'(sends), 32'd4);
        drive(1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 1'b1, 110);
        #2;
        chk("exhaust_req", 101, 32'(arb_req), 32'd0);
        @(posedge clk);
        #1;
        chk("exhaust_ov_idle", 102, 32'(out_valid), 32'd0);
        drive(1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 1'b0, 111);
        #1;
        arb_grant = arb_req;
        #1;
        chk("refill_pop", 103, 32'(in_pop), 32'b00001);
        @(posedge clk);
        #1;
        chk("refill_ov",   104, 32'(out_valid), 32'd1);
        chk("refill_flit", 104, out_flit, flit_of(0, 111));
        chk("refill_err",  104, 32'(err), 32'd0);
        chk("refill_cred", 104, 32'(dut.w_credits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
